// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: accepts one fetch request, waits WAIT_CYCLES,
// returns the word (or an error response); back-door load port and flush cancel.
module instr_mem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ERR_INSTR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_instr,
    output logic [31:0] resp_addr,
    output logic        resp_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);
    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        wait_cnt_reg, wait_cnt_next;
    logic [31:0]       addr_reg, addr_next;
    logic              req_ready_reg, req_ready_next;
    logic              resp_valid_reg, resp_valid_next;
    logic [31:0]       resp_instr_reg, resp_addr_reg;
    logic              resp_err_reg;
    logic              accept, load_resp, addr_err;
    logic [ADDR_W-1:0] rd_idx, wr_idx;
    logic              unused_ld_bits;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept    = (state_reg == S_IDLE) && req_valid && !flush;
    // The edge that leaves WAIT with the count exhausted is the RESP entry edge,
    // which puts resp_valid WAIT_CYCLES+1 edges after the accepting edge.
    assign load_resp = (state_reg == S_WAIT) && !flush && (wait_cnt_reg == 4'd0);
    assign rd_idx    = addr_reg[ADDR_W+1:2];
    assign wr_idx    = ld_addr[ADDR_W+1:2];
    assign addr_err  = (addr_reg[1:0] != 2'b00) || (addr_reg[31:ADDR_W+2] != '0);
    assign unused_ld_bits = ^{ld_addr[31:ADDR_W+2], ld_addr[1:0]};

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[wr_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            wait_cnt_reg   <= 4'd0;
            addr_reg       <= 32'h0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_instr_reg <= 32'h0;
            resp_addr_reg  <= 32'h0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            addr_reg       <= addr_next;
            req_ready_reg  <= req_ready_next;
            resp_valid_reg <= resp_valid_next;
            if (load_resp) begin
                resp_instr_reg <= addr_err ? ERR_INSTR : mem[rd_idx];
                resp_addr_reg  <= addr_reg;
                resp_err_reg   <= addr_err;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = S_WAIT;
            S_WAIT: begin
                if (flush)                        state_next = S_IDLE;
                else if (wait_cnt_reg == 4'd0)    state_next = S_RESP;
            end
            // flush wins over resp_ready, but both end in IDLE
            S_RESP: if (flush || resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_next   = wait_cnt_reg;
        addr_next       = addr_reg;
        if (accept) begin
            wait_cnt_next = 4'(WAIT_CYCLES);
            addr_next     = req_addr;
        end else if ((state_reg == S_WAIT) && (wait_cnt_reg != 4'd0)) begin
            wait_cnt_next = wait_cnt_reg - 4'd1;
        end
        req_ready_next  = (state_next == S_IDLE);
        resp_valid_next = (state_next == S_RESP);
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_instr = resp_instr_reg;
    assign resp_addr  = resp_addr_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboarded random test of two responder instances (WAIT_CYCLES=2 and 0)
// against a word-array reference model.
module tb_instr_mem_responder;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset      [2];
    logic        req_valid  [2];
    logic [31:0] req_addr   [2];
    logic        req_ready  [2];
    logic        flush      [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_instr [2];
    logic [31:0] resp_addr  [2];
    logic        resp_err   [2];
    logic        ld_en      [2];
    logic [31:0] ld_addr    [2];
    logic [31:0] ld_data    [2];

    logic [31:0] mdl_mem [2][64];
    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            instr_mem_responder #(
                .DEPTH_WORDS (64),
                .WAIT_CYCLES ((gi == 0) ? 2 : 0),
                .ERR_INSTR   (32'h0000_0000)
            ) u_dut (
                .clk        (clk),
                .reset      (reset[gi]),
                .req_valid  (req_valid[gi]),
                .req_addr   (req_addr[gi]),
                .req_ready  (req_ready[gi]),
                .flush      (flush[gi]),
                .resp_valid (resp_valid[gi]),
                .resp_ready (resp_ready[gi]),
                .resp_instr (resp_instr[gi]),
                .resp_addr  (resp_addr[gi]),
                .resp_err   (resp_err[gi]),
                .ld_en      (ld_en[gi]),
                .ld_addr    (ld_addr[gi]),
                .ld_data    (ld_data[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %h, expected %h", name, k, act, exp);
        end
    endfunction

    // Reference: the response follows directly from the address rules and word array.
    function automatic exp_t model(int k, logic [31:0] a);
        exp_t e;
        e.addr = a;
        if (a[1:0] != 2'b00 || a[31:2] >= 30'd64) begin
            e.err   = 1'b1;
            e.instr = 32'h0;
        end else begin
            e.err   = 1'b0;
            e.instr = mdl_mem[k][a[7:2]];
        end
        return e;
    endfunction

    function automatic void push_exp(int k, exp_t e);
        if (k == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endfunction

    function automatic void drop_exp(int k);
        if (k == 0 && exp_q0.size() > 0) void'(exp_q0.pop_back());
        if (k == 1 && exp_q1.size() > 0) void'(exp_q1.pop_back());
    endfunction

    function automatic int lat_of(int k);
        return (k == 0) ? 3 : 1;
    endfunction

    // Monitor: every consumed response is matched against the queue head.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset[k] && resp_valid[k] && resp_ready[k] && !flush[k]) begin
                exp_t e;
                int   sz;
                sz = (k == 0) ? exp_q0.size() : exp_q1.size();
                if (sz == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp inst%0d: got addr %h, expected none", k, resp_addr[k]);
                end else begin
                    e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    $display("txn inst%0d addr=%h instr=%h err=%0d", k, resp_addr[k], resp_instr[k], resp_err[k]);
                    check("resp_instr", k, resp_instr[k], e.instr);
                    check("resp_addr",  k, resp_addr[k],  e.addr);
                    check("resp_err",   k, 32'(resp_err[k]), 32'(e.err));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(int k, int w, logic [31:0] d);
        logic [31:0] la;
        la = $urandom();
        la[7:2] = w[5:0];
        ld_en[k] = 1'b1; ld_addr[k] = la; ld_data[k] = d;
        step();
        ld_en[k] = 1'b0;
        mdl_mem[k][w] = d;
    endtask

    // Accept and wait until resp_valid; optionally load ld_w on the RESP entry edge.
    task automatic accept_and_wait(int k, logic [31:0] a, int ld_w, logic [31:0] ld_d,
                                   output int n);
        logic [31:0] la;
        check("req_ready_idle", k, 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1; req_addr[k] = a;
        step();
        req_valid[k] = 1'($urandom_range(0, 1)); req_addr[k] = $urandom();
        n = 0;
        do begin
            n++;
            if (n == lat_of(k) && ld_w >= 0) begin
                la = $urandom(); la[7:2] = ld_w[5:0];
                ld_en[k] = 1'b1; ld_addr[k] = la; ld_data[k] = ld_d;
            end
            step();
            if (ld_en[k]) begin
                ld_en[k] = 1'b0;
                mdl_mem[k][ld_w] = ld_d;
            end
        end while (!resp_valid[k] && n < 40);
    endtask

    task automatic do_req(int k, logic [31:0] a, int hold, int ld_w, logic [31:0] ld_d);
        int n;
        logic [31:0] held;
        push_exp(k, model(k, a));
        accept_and_wait(k, a, ld_w, ld_d, n);
        check("latency", k, 32'(n), 32'(lat_of(k)));
        check("req_ready_busy", k, 32'(req_ready[k]), 32'd0);
        held = resp_instr[k];
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", k, 32'(resp_valid[k]), 32'd1);
            check("hold_instr", k, resp_instr[k], held);
        end
        resp_ready[k] = 1'b1; req_valid[k] = 1'b0;
        step();
        resp_ready[k] = 1'b0;
        check("valid_after_ack", k, 32'(resp_valid[k]), 32'd0);
        check("ready_after_ack", k, 32'(req_ready[k]), 32'd1);
    endtask

    task automatic do_flush_wait(int k, logic [31:0] a);
        check("req_ready_idle", k, 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1; req_addr[k] = a;
        step();
        req_valid[k] = 1'b0;
        check("valid_pre_flush", k, 32'(resp_valid[k]), 32'd0);
        flush[k] = 1'b1;
        step();
        flush[k] = 1'b0;
        $display("txn inst%0d addr=%h flushed in wait", k, a);
        check("flush_ready", k, 32'(req_ready[k]), 32'd1);
        for (int i = 0; i < lat_of(k) + 1; i++) begin
            check("flush_no_valid", k, 32'(resp_valid[k]), 32'd0);
            step();
        end
    endtask

    task automatic do_flush_resp(int k, logic [31:0] a);
        int n;
        accept_and_wait(k, a, -1, 32'h0, n);
        req_valid[k] = 1'b0;
        check("flush_resp_valid", k, 32'(resp_valid[k]), 32'd1);
        flush[k] = 1'b1; resp_ready[k] = 1'b1;
        step();
        flush[k] = 1'b0; resp_ready[k] = 1'b0;
        $display("txn inst%0d addr=%h flushed in resp", k, a);
        check("flush_resp_drop", k, 32'(resp_valid[k]), 32'd0);
        check("flush_resp_ready", k, 32'(req_ready[k]), 32'd1);
    endtask

    task automatic do_flush_idle(int k);
        req_valid[k] = 1'b1; req_addr[k] = 32'h0; flush[k] = 1'b1;
        step();
        req_valid[k] = 1'b0; flush[k] = 1'b0;
        check("flush_idle_ready", k, 32'(req_ready[k]), 32'd1);
        for (int i = 0; i < lat_of(k) + 1; i++) begin
            step();
            check("flush_idle_no_valid", k, 32'(resp_valid[k]), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(int k);
        check("rst_req_ready",  k, 32'(req_ready[k]), 32'd1);
        check("rst_resp_valid", k, 32'(resp_valid[k]), 32'd0);
        check("rst_resp_instr", k, resp_instr[k], 32'h0);
        check("rst_resp_addr",  k, resp_addr[k], 32'h0);
        check("rst_resp_err",   k, 32'(resp_err[k]), 32'd0);
    endtask

    task automatic do_async_reset(int k);
        int n;
        push_exp(k, model(k, 32'h4));
        accept_and_wait(k, 32'h4, -1, 32'h0, n);
        req_valid[k] = 1'b0;
        check("pre_reset_valid", k, 32'(resp_valid[k]), 32'd1);
        #3;
        reset[k] = 1'b0;
        #1;
        check_reset_outputs(k);
        drop_exp(k);
        step();
        reset[k] = 1'b1;
        step();
        do_req(k, 32'h0, 0, -1, 32'h0);
    endtask

    task automatic run_random(int k, int iters);
        logic [31:0] a;
        for (int i = 0; i < iters; i++) begin
            int r;
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 9))
                0: a = {$urandom_range(0, 63), 2'b00} | 32'($urandom_range(1, 3));
                1: a = 32'h100 + 32'($urandom_range(0, 255));
                2: a = $urandom();
                default: a = 32'($urandom_range(0, 63)) << 2;
            endcase
            if (r == 0)      load(k, $urandom_range(0, 63), $urandom());
            else if (r == 1) do_flush_wait(k, a);
            else             do_req(k, a, $urandom_range(0, 3), -1, 32'h0);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b0; req_valid[k] = 1'b0; req_addr[k] = 32'h0;
            flush[k] = 1'b0; resp_ready[k] = 1'b0; ld_en[k] = 1'b0;
            ld_addr[k] = 32'h0; ld_data[k] = 32'h0;
        end
        step();
        step();
        for (int k = 0; k < 2; k++) check_reset_outputs(k);
        for (int k = 0; k < 2; k++) reset[k] = 1'b1;
        step();

        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 64; w++) load(k, w, $urandom());
            load(k, 0, 32'h2008_0001);
            load(k, 1, 32'h2009_0002);
            load(k, 2, 32'h0109_5020);
            load(k, 3, 32'hAC0A_0000);

            do_req(k, 32'h0, 0, -1, 32'h0);
            do_req(k, 32'h4, 3, -1, 32'h0);
            do_req(k, 32'hE, 1, -1, 32'h0);
            do_req(k, 32'h100, 0, -1, 32'h0);
            do_flush_wait(k, 32'h8);
            do_req(k, 32'hC, 0, -1, 32'h0);
            do_flush_idle(k);
            do_flush_resp(k, 32'h8);
            do_req(k, 32'h4, 0, 1, 32'h1234_5678);
            do_req(k, 32'h4, 0, -1, 32'h0);
            load(k, 1, 32'h2009_0002);
            do_async_reset(k);
            run_random(k, 30);
        end

        repeat (4) step();
        check("leftover_q0", 0, 32'(exp_q0.size()), 32'd0);
        check("leftover_q1", 1, 32'(exp_q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
